// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, status/control bit positions, frame size.
// Used by both the transmit and receive blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int ST_THRE     = 0;
  localparam int ST_IDLE     = 1;
  localparam int ST_OVR      = 2;
  localparam int CTRL_IRQ_EN = 0;
  localparam int DATA_BITS   = 8;

  function automatic logic [7:0] status_byte(input logic ovr, input logic idle, input logic thre);
    logic [7:0] s;
    s          = 8'h00;
    s[ST_OVR]  = ovr;
    s[ST_IDLE] = idle;
    s[ST_THRE] = thre;
    return s;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts 0..CLOCK_DIVISOR-1 and flags the last cycle of each bit.
// restart_i forces the count back to 0 so every new bit starts with a full period.
module uart_baud_tick #(
  parameter int CLOCK_DIVISOR = 4618,
  parameter int CNT_W         = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCK_DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_interface.sv
// 8N1 UART transmitter with a one-byte holding register and 6809 register interface.
// Drives the FT2232 RX line; raises an active-low interrupt while the holding register is empty.
module uart_tx_interface
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVISOR = 4618,
  parameter int CNT_W         = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_data_ce,
  input  logic       uart_status_ce,
  input  logic       uart_control_ce,
  input  logic       i_RW,
  input  logic [7:0] i_DATA_BUS,
  output logic       o_UART_RX,
  output logic [7:0] o_DATA,
  output logic       o_IRQ
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic       overrun_q, overrun_d;
  logic       irq_en_q, irq_en_d;
  logic       line_q, line_d;
  logic [7:0] data_q, data_d;
  logic       irq_q;
  logic       wr_data_prev_q, wr_ctrl_prev_q, rd_stat_prev_q;
  logic       wr_data_lvl, wr_ctrl_lvl, rd_stat_lvl;
  logic       wr_data, wr_ctrl, rd_stat;
  logic       load, restart, tick, tx_idle, wr_ok;

  // Bus cycles hold CE for many clocks; act only on the first cycle of each access.
  assign wr_data_lvl = uart_data_ce & ~i_RW;
  assign wr_ctrl_lvl = uart_control_ce & ~i_RW;
  assign rd_stat_lvl = uart_status_ce & i_RW;
  assign wr_data     = wr_data_lvl & ~wr_data_prev_q;
  assign wr_ctrl     = wr_ctrl_lvl & ~wr_ctrl_prev_q;
  assign rd_stat     = rd_stat_lvl & ~rd_stat_prev_q;

  assign tx_idle = (state_q == IDLE) & ~thr_full_q;
  assign restart = (state_d != state_q) | (state_q == IDLE);

  uart_baud_tick #(
    .CLOCK_DIVISOR(CLOCK_DIVISOR),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart_i(restart),
    .tick_o   (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (thr_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // A queued byte follows the stop bit with no idle gap.
        if (tick) begin
          if (thr_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_q[bit_idx_q];
      default: line_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ok      = ~thr_full_q | load;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    shift_d    = load ? thr_q : shift_q;
    irq_en_d   = wr_ctrl ? i_DATA_BUS[CTRL_IRQ_EN] : irq_en_q;
    overrun_d  = overrun_q;
    if (load) begin
      thr_full_d = 1'b0;
    end
    if (wr_data && wr_ok) begin
      thr_d      = i_DATA_BUS;
      thr_full_d = 1'b1;
    end
    // A new overrun in the same cycle as a status read keeps the flag set.
    if (rd_stat) begin
      overrun_d = 1'b0;
    end
    if (wr_data && !wr_ok) begin
      overrun_d = 1'b1;
    end
    data_d = data_q;
    if (uart_status_ce && i_RW) begin
      data_d = status_byte(overrun_q, tx_idle, ~thr_full_q);
    end else if (uart_control_ce && i_RW) begin
      data_d = {7'b0, irq_en_q};
    end else if (uart_data_ce && i_RW) begin
      data_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_idx_q      <= 3'd0;
      shift_q        <= 8'h00;
      thr_q          <= 8'h00;
      thr_full_q     <= 1'b0;
      overrun_q      <= 1'b0;
      irq_en_q       <= 1'b0;
      line_q         <= 1'b1;
      data_q         <= 8'h00;
      irq_q          <= 1'b1;
      wr_data_prev_q <= 1'b0;
      wr_ctrl_prev_q <= 1'b0;
      rd_stat_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      thr_q          <= thr_d;
      thr_full_q     <= thr_full_d;
      overrun_q      <= overrun_d;
      irq_en_q       <= irq_en_d;
      line_q         <= line_d;
      data_q         <= data_d;
      irq_q          <= ~(irq_en_q & ~thr_full_q);
      wr_data_prev_q <= wr_data_lvl;
      wr_ctrl_prev_q <= wr_ctrl_lvl;
      rd_stat_prev_q <= rd_stat_lvl;
    end
  end

  assign o_UART_RX = line_q;
  assign o_DATA    = data_q;
  assign o_IRQ     = irq_q;

endmodule
